// File: rtl/difftest_commit_sched_pkg.sv
// Shared types for the difftest commit scheduler: per-slot commit info and buffered entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package difftest_commit_sched_pkg;

  localparam int DIFFTEST_XLEN  = 32;
  // Storage width of the sequence tag; the scheduler's CNT_W must not exceed it.
  localparam int DIFFTEST_SEQ_W = 64;

  typedef struct packed {
    logic                     commit;
    logic                     skip;
    logic [DIFFTEST_XLEN-1:0] pc;
    logic [DIFFTEST_XLEN-1:0] inst;
  } difftest_info_t;

  typedef struct packed {
    logic [DIFFTEST_XLEN-1:0]  pc;
    logic [DIFFTEST_XLEN-1:0]  inst;
    logic                      skip;
    logic [DIFFTEST_SEQ_W-1:0] seq;
  } difftest_entry_t;

  // Build a buffered entry from one commit slot and its sequence tag.
  function automatic difftest_entry_t make_entry(input difftest_info_t info,
                                                 input logic [DIFFTEST_SEQ_W-1:0] seq);
    difftest_entry_t e;
    e.pc   = info.pc;
    e.inst = info.inst;
    e.skip = info.skip;
    e.seq  = seq;
    return e;
  endfunction

endpackage

// File: rtl/difftest_commit_sched_if.sv
// Commit-side and checker-side handshake bundle of the difftest commit scheduler.
// Latency: n/a (wires only).
// Backpressure: in_ready toward the core, out_ready from the checker.
interface difftest_commit_sched_if #(
  parameter int CNT_W = 64
);
  import difftest_commit_sched_pkg::*;

  difftest_info_t [1:0]     diff_in;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [DIFFTEST_XLEN-1:0] out_pc;
  logic [DIFFTEST_XLEN-1:0] out_inst;
  logic                     out_skip;
  logic [CNT_W-1:0]         out_seq;

  // Core plus checker side: offers commits, accepts drained entries.
  modport master (
    output diff_in, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_skip, out_seq
  );

  // Scheduler side.
  modport slave (
    input  diff_in, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_skip, out_seq
  );

endinterface

// File: rtl/difftest_commit_sched_fifo2w.sv
// difftest_fifo2w: storage with up to two writes and one read per cycle, pointers and occupancy count.
// Latency: a written entry is readable from the next cycle.
// Backpressure: none internally; the caller limits wr_n to free space and only reads when count != 0.
module difftest_fifo2w
  import difftest_commit_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 wr_n,
  input  difftest_entry_t            wr_dat0,
  input  difftest_entry_t            wr_dat1,
  input  logic                       rd_en,
  output difftest_entry_t            rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  difftest_entry_t mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr_p1;

  assign wptr_p1 = wptr + AW'(1);
  assign rd_dat  = mem[rptr];

  // Array writes: first entry at wptr, second (if any) right behind it; storage needs no reset.
  always_ff @(posedge clock) begin
    if (wr_n != 2'd0) mem[wptr]    <= wr_dat0;
    if (wr_n == 2'd2) mem[wptr_p1] <= wr_dat1;
  end

  // Pointer and count update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_n);
      rptr  <= rptr + AW'(rd_en);
      count <= count + CW'(wr_n) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/difftest_commit_sched.sv
// difftest_commit_sched: buffers up to two in-order commits per cycle, drains one tagged entry per cycle.
// Latency: an accepted commit reaches the checker output one cycle later at the earliest.
// Backpressure: in_ready needs two free entries; commits offered while it is low are dropped and set overflow.
// Optional: define DIFFTEST_ORDER_CHECK_EN to build the slot-order/duplicate-pc check driving order_err.
module difftest_commit_sched
  import difftest_commit_sched_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 10000,
  parameter int CNT_W   = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  difftest_commit_sched_if.slave io,
  output logic [CNT_W-1:0]       commit_cnt,
  output logic [CNT_W-1:0]       skip_cnt,
  output logic                   timeout,
  output logic                   overflow,
  output logic                   order_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  difftest_info_t  slot0;
  difftest_info_t  slot1;
  logic [1:0]      n_in;
  logic            in_rdy;
  logic            accept;
  logic            out_vld;
  logic            pop;
  logic [1:0]      wr_n;
  difftest_entry_t wr_dat0;
  difftest_entry_t wr_dat1;
  difftest_entry_t head;
  logic [CW-1:0]   count;
  logic [CNT_W-1:0] seq_cnt;
  logic [CNT_W-1:0] seq_p1;
  logic [WDW-1:0]  wd_cnt;
  logic [WDW-1:0]  wd_next;

  assign slot0  = io.diff_in[0];
  assign slot1  = io.diff_in[1];
  assign n_in   = {1'b0, slot0.commit} + {1'b0, slot1.commit};

  // Only the registered count gates input, so a same-cycle pop never widens the window.
  assign in_rdy = (count <= CW'(DEPTH - 2));
  assign accept = in_rdy && (n_in != 2'd0);
  assign wr_n   = in_rdy ? n_in : 2'd0;

  // Compaction: the oldest committing slot always lands at wptr.
  assign seq_p1  = seq_cnt + CNT_W'(1);
  assign wr_dat0 = slot0.commit ? make_entry(slot0, DIFFTEST_SEQ_W'(seq_cnt))
                                : make_entry(slot1, DIFFTEST_SEQ_W'(seq_cnt));
  assign wr_dat1 = make_entry(slot1, DIFFTEST_SEQ_W'(seq_p1));

  assign out_vld = (count != '0);
  assign pop     = out_vld && io.out_ready;

  difftest_fifo2w #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_n    (wr_n),
    .wr_dat0 (wr_dat0),
    .wr_dat1 (wr_dat1),
    .rd_en   (pop),
    .rd_dat  (head),
    .count   (count)
  );

  // Head fields are masked while empty so stale storage never shows on the bus.
  assign io.in_ready  = in_rdy;
  assign io.out_valid = out_vld;
  assign io.out_pc    = out_vld ? head.pc   : '0;
  assign io.out_inst  = out_vld ? head.inst : '0;
  assign io.out_skip  = out_vld ? head.skip : 1'b0;
  assign io.out_seq   = out_vld ? CNT_W'(head.seq) : '0;

  // Sequence tagging, pop statistics and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt    <= '0;
      commit_cnt <= '0;
      skip_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) seq_cnt <= seq_cnt + CNT_W'(n_in);
      if (pop) begin
        if (head.skip) skip_cnt   <= skip_cnt + CNT_W'(1);
        else           commit_cnt <= commit_cnt + CNT_W'(1);
      end
      if (!in_rdy && (n_in != 2'd0)) overflow <= 1'b1;
    end
  end

  // Watchdog next value: cleared by accepted commits, otherwise counts up and saturates.
  always_comb begin
    wd_next = wd_cnt;
    if (accept)                       wd_next = '0;
    else if (wd_cnt != WDW'(TIMEOUT)) wd_next = wd_cnt + WDW'(1);
  end

  // Watchdog counter; timeout rises on the same edge the counter reaches TIMEOUT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next == WDW'(TIMEOUT)) timeout <= 1'b1;
    end
  end

`ifdef DIFFTEST_ORDER_CHECK_EN
  logic order_hit;

  assign order_hit = (in_rdy && slot1.commit && !slot0.commit) ||
                     (slot0.commit && slot1.commit && (slot1.pc == slot0.pc));

  // Sticky flag for a younger-only commit or a duplicated pc across the two slots.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       order_err <= 1'b0;
    else if (order_hit) order_err <= 1'b1;
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_difftest_commit_sched.sv
module tb_difftest_commit_sched;
  import difftest_commit_sched_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  difftest_commit_sched_if #(.CNT_W(64)) if8 ();
  difftest_commit_sched_if #(.CNT_W(64)) if4 ();

  logic [63:0] cc8, sc8, cc4, sc4;
  logic        to8, of8, oe8, to4, of4, oe4;

  difftest_commit_sched #(.DEPTH(8), .TIMEOUT(5), .CNT_W(64)) u_d8 (
    .clock(clock), .reset_n(reset_n), .io(if8.slave),
    .commit_cnt(cc8), .skip_cnt(sc8), .timeout(to8), .overflow(of8), .order_err(oe8));

  difftest_commit_sched #(.DEPTH(4), .TIMEOUT(5), .CNT_W(64)) u_d4 (
    .clock(clock), .reset_n(reset_n), .io(if4.slave),
    .commit_cnt(cc4), .skip_cnt(sc4), .timeout(to4), .overflow(of4), .order_err(oe4));

  int total = 0;
  int bad   = 0;
  int pops8 = 0;
  int pops4 = 0;
  difftest_entry_t q8[$];
  difftest_entry_t q4[$];

  function automatic difftest_info_t mk(input logic c, input logic s,
                                        input logic [31:0] pc, input logic [31:0] inst);
    difftest_info_t r;
    r.commit = c; r.skip = s; r.pc = pc; r.inst = inst;
    return r;
  endfunction

  function automatic difftest_entry_t ex(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic s, input logic [63:0] seq);
    difftest_entry_t r;
    r.pc = pc; r.inst = inst; r.skip = s; r.seq = seq;
    return r;
  endfunction

  // Scoreboard for the DEPTH=8 instance: every pop must match the oldest expected entry.
  always @(negedge clock) begin : mon8
    difftest_entry_t e;
    if (reset_n && if8.out_valid && if8.out_ready) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL d8_pop unexpected: got pc=%h seq=%0d, expected no entry", if8.out_pc, if8.out_seq);
      end else begin
        e = q8.pop_front();
        if (if8.out_pc !== e.pc || if8.out_inst !== e.inst || if8.out_skip !== e.skip || if8.out_seq !== e.seq) begin
          bad++;
          $display("FAIL d8_pop: got pc=%h inst=%h skip=%b seq=%0d, expected pc=%h inst=%h skip=%b seq=%0d",
                   if8.out_pc, if8.out_inst, if8.out_skip, if8.out_seq, e.pc, e.inst, e.skip, e.seq);
        end
      end
      pops8++;
    end
  end

  // Scoreboard for the DEPTH=4 instance.
  always @(negedge clock) begin : mon4
    difftest_entry_t e;
    if (reset_n && if4.out_valid && if4.out_ready) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL d4_pop unexpected: got pc=%h seq=%0d, expected no entry", if4.out_pc, if4.out_seq);
      end else begin
        e = q4.pop_front();
        if (if4.out_pc !== e.pc || if4.out_inst !== e.inst || if4.out_skip !== e.skip || if4.out_seq !== e.seq) begin
          bad++;
          $display("FAIL d4_pop: got pc=%h inst=%h skip=%b seq=%0d, expected pc=%h inst=%h skip=%b seq=%0d",
                   if4.out_pc, if4.out_inst, if4.out_skip, if4.out_seq, e.pc, e.inst, e.skip, e.seq);
        end
      end
      pops4++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    if8.diff_in = '0;
    if4.diff_in = '0;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    idle_inputs();
    if8.out_ready = 1'b0;
    if4.out_ready = 1'b0;
    q8.delete();
    q4.delete();
    pops8 = 0;
    pops4 = 0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && q8.size() != 0; i++) tick();
    tick();
    total++;
    if (q8.size() != 0) begin bad++; $display("FAIL d8_drain: %0d entries left, expected 0", q8.size()); end
  endtask

  task automatic test_reset();
    #1;
    total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", if8.out_valid); end
    total++; if (if8.in_ready !== 1'b1 || if4.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b/%b expected 1/1", if8.in_ready, if4.in_ready); end
    total++; if (if8.out_pc !== 32'h0 || if8.out_seq !== 64'h0 || if8.out_skip !== 1'b0) begin bad++; $display("FAIL rst_out_bus: pc=%h seq=%0d skip=%b expected zeros", if8.out_pc, if8.out_seq, if8.out_skip); end
    // Fill three entries, then reset asynchronously mid-cycle.
    reset_n = 1'b1;
    tick();
    if8.diff_in[0] = mk(1'b1, 1'b0, 32'h1000, 32'h13);
    if8.diff_in[1] = mk(1'b1, 1'b0, 32'h1004, 32'h13);
    tick();
    if8.diff_in[1] = '0;
    tick();
    idle_inputs();
    total++; if (if8.out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid: got %b expected 1", if8.out_valid); end
    reset_n = 1'b0;
    #2;
    total++; if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_flags: valid=%b in_ready=%b expected 0/1", if8.out_valid, if8.in_ready); end
    total++; if (cc8 !== 64'd0 || sc8 !== 64'd0) begin bad++; $display("FAIL midrst_cnts: commit=%0d skip=%0d expected 0/0", cc8, sc8); end
    total++; if (to8 !== 1'b0 || of8 !== 1'b0 || oe8 !== 1'b0) begin bad++; $display("FAIL midrst_sticky: to=%b of=%b oe=%b expected 000", to8, of8, oe8); end
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_dual();
    apply_reset();
    if8.out_ready  = 1'b1;
    if8.diff_in[0] = mk(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0093);
    if8.diff_in[1] = mk(1'b1, 1'b1, 32'h8000_0004, 32'h0000_0113);
    q8.push_back(ex(32'h8000_0000, 32'h0000_0093, 1'b0, 64'd0));
    q8.push_back(ex(32'h8000_0004, 32'h0000_0113, 1'b1, 64'd1));
    @(negedge clock);
    total++; if (if8.out_valid !== 1'b0) begin bad++; $display("FAIL dual_latency: out_valid=%b expected 0", if8.out_valid); end
    tick();
    idle_inputs();
    drain8();
    total++; if (pops8 != 2) begin bad++; $display("FAIL dual_pops: got %0d expected 2", pops8); end
    total++; if (cc8 !== 64'd1 || sc8 !== 64'd1) begin bad++; $display("FAIL dual_cnts: commit=%0d skip=%0d expected 1/1", cc8, sc8); end
    total++; if (oe8 !== 1'b0) begin bad++; $display("FAIL dual_order_err: got %b expected 0", oe8); end
  endtask

  task automatic test_slot1_only();
    logic exp_oe;
`ifdef DIFFTEST_ORDER_CHECK_EN
    exp_oe = 1'b1;
`else
    exp_oe = 1'b0;
`endif
    apply_reset();
    if8.diff_in[1] = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0013);
    q8.push_back(ex(32'h0000_0100, 32'h0000_0013, 1'b0, 64'd0));
    tick();
    idle_inputs();
    total++; if (if8.out_valid !== 1'b1 || if8.out_pc !== 32'h100 || if8.out_seq !== 64'd0) begin bad++; $display("FAIL slot1_head: valid=%b pc=%h seq=%0d expected 1/100/0", if8.out_valid, if8.out_pc, if8.out_seq); end
    total++; if (oe8 !== exp_oe) begin bad++; $display("FAIL slot1_order_err: got %b expected %b", oe8, exp_oe); end
    if8.out_ready = 1'b1;
    drain8();
    total++; if (pops8 != 1 || cc8 !== 64'd1) begin bad++; $display("FAIL slot1_pops: pops=%0d commit=%0d expected 1/1", pops8, cc8); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      if4.diff_in[0] = mk(1'b1, 1'b0, 32'h4000 + 32'(8 * c), 32'h33);
      if4.diff_in[1] = mk(1'b1, 1'b0, 32'h4004 + 32'(8 * c), 32'h33);
      if (c < 2) begin
        q4.push_back(ex(32'h4000 + 32'(8 * c), 32'h33, 1'b0, 64'(2 * c)));
        q4.push_back(ex(32'h4004 + 32'(8 * c), 32'h33, 1'b0, 64'(2 * c + 1)));
      end
      tick();
      if (c == 0) begin
        total++; if (if4.in_ready !== 1'b1 || of4 !== 1'b0) begin bad++; $display("FAIL bp_cycle1: in_ready=%b overflow=%b expected 1/0", if4.in_ready, of4); end
      end else if (c == 1) begin
        total++; if (if4.in_ready !== 1'b0 || of4 !== 1'b0) begin bad++; $display("FAIL bp_cycle2: in_ready=%b overflow=%b expected 0/0", if4.in_ready, of4); end
      end else begin
        total++; if (of4 !== 1'b1) begin bad++; $display("FAIL bp_overflow: got %b expected 1", of4); end
      end
    end
    idle_inputs();
    if4.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    total++; if (pops4 != 4 || q4.size() != 0) begin bad++; $display("FAIL bp_pops: pops=%0d left=%0d expected 4/0", pops4, q4.size()); end
    total++; if (cc4 !== 64'd4 || of4 !== 1'b1 || if4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_final: commit=%0d overflow=%b in_ready=%b expected 4/1/1", cc4, of4, if4.in_ready); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    total++; if (to8 !== 1'b0) begin bad++; $display("FAIL wd_early: timeout=%b after 4 idle cycles expected 0", to8); end
    tick();
    total++; if (to8 !== 1'b1) begin bad++; $display("FAIL wd_fire: timeout=%b after 5 idle cycles expected 1", to8); end
    if8.out_ready  = 1'b1;
    if8.diff_in[0] = mk(1'b1, 1'b0, 32'h3000, 32'h73);
    q8.push_back(ex(32'h3000, 32'h73, 1'b0, 64'd0));
    tick();
    idle_inputs();
    drain8();
    total++; if (to8 !== 1'b1) begin bad++; $display("FAIL wd_sticky: timeout=%b after commit expected 1", to8); end
  endtask

  task automatic test_wrap();
    int sent;
    apply_reset();
    sent = 0;
    for (int cyc = 0; cyc < 300 && (sent < 20 || q8.size() != 0); cyc++) begin
      if8.out_ready = (cyc % 2 == 0);
      if (sent < 20 && if8.in_ready === 1'b1) begin
        if8.diff_in[0] = mk(1'b1, 1'b0, 32'h2000 + 32'(4 * sent), 32'h1000_0000 + 32'(sent));
        q8.push_back(ex(32'h2000 + 32'(4 * sent), 32'h1000_0000 + 32'(sent), 1'b0, 64'(sent)));
        sent++;
      end else begin
        if8.diff_in = '0;
      end
      tick();
    end
    idle_inputs();
    if8.out_ready = 1'b0;
    tick();
    total++; if (sent != 20 || q8.size() != 0) begin bad++; $display("FAIL wrap_progress: sent=%0d left=%0d expected 20/0", sent, q8.size()); end
    total++; if (pops8 != 20 || cc8 !== 64'd20) begin bad++; $display("FAIL wrap_cnts: pops=%0d commit=%0d expected 20/20", pops8, cc8); end
    total++; if (of8 !== 1'b0) begin bad++; $display("FAIL wrap_overflow: got %b expected 0", of8); end
  endtask

  initial begin
    if8.diff_in = '0; if8.out_ready = 1'b0;
    if4.diff_in = '0; if4.out_ready = 1'b0;
    test_reset();
    test_dual();
    test_slot1_only();
    test_backpressure();
    test_watchdog();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
